// File: rtl/ram_arb_pkg.sv
// Shared definitions for the PHI2-slotted SDRAM arbiter: FSM states,
// requester indices and the default slot timing parameters.
// No logic; imported by the arbiter and its testbench.
package ram_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_ARMED = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } arb_state_t;

    localparam logic [1:0] PORT_CPU = 2'd0;
    localparam logic [1:0] PORT_D0  = 2'd1;
    localparam logic [1:0] PORT_D1  = 2'd2;

    localparam int RD_LAT_DEF     = 5;
    localparam int INIT_SLOTS_DEF = 1;

endpackage

// File: rtl/phi2_sync.sv
// Brings the asynchronous 6502 PHI2 into the C8M domain and flags its edges.
// Latency: rise/fall pulses are valid one cycle after PHI2 is first sampled.
// No backpressure: pulses are single-cycle and must be consumed when seen.
module phi2_sync (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_phi2,
    output logic o_rise,
    output logic o_fall
);

    logic r_p1;
    logic r_p2;

    // Two-flop synchronizer; the second stage doubles as the edge history.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_p1 <= 1'b0;
            r_p2 <= 1'b0;
        end else begin
            r_p1 <= i_phi2;
            r_p2 <= r_p1;
        end
    end

    assign o_rise = r_p1 & ~r_p2;
    assign o_fall = ~r_p1 & r_p2;

endmodule

// File: rtl/ram_arbiter.sv
// Grants the single SDRAM slot of each PHI2 cycle to CPU, DMA0 or DMA1.
// Latency: command 2 cycles after PHI2 rise; DONE RD_LAT+1 cycles after fall detect.
// Requesters hold REQ/WE/A/WD until their DONE; ungranted requests wait for the next slot.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int RD_LAT     = RD_LAT_DEF,
    parameter int INIT_SLOTS = INIT_SLOTS_DEF
) (
    input  logic        i_c8m,
    input  logic        i_reset,
    input  logic        i_phi2,
    input  logic        i_cpureq,
    input  logic        i_cpuwe,
    input  logic [23:0] i_cpua,
    input  logic [7:0]  i_cpuwd,
    output logic [7:0]  o_cpurd,
    output logic        o_cpudone,
    input  logic        i_d0req,
    input  logic        i_d0we,
    input  logic [23:0] i_d0a,
    input  logic [7:0]  i_d0wd,
    output logic [7:0]  o_d0rd,
    output logic        o_d0done,
    input  logic        i_d1req,
    input  logic        i_d1we,
    input  logic [23:0] i_d1a,
    input  logic [7:0]  i_d1wd,
    output logic [7:0]  o_d1rd,
    output logic        o_d1done,
    output logic        o_rdcmd,
    output logic        o_wrcmd,
    output logic [23:0] o_a,
    output logic [7:0]  o_wrd,
    input  logic [7:0]  i_rdd
);

    localparam logic [3:0] LAT_M1 = 4'(RD_LAT - 1);
    localparam logic [1:0] INIT_N = 2'(INIT_SLOTS);

    logic        w_rise;
    logic        w_fall;
    arb_state_t  r_state;
    arb_state_t  w_next;
    logic [3:0]  r_cnt;
    logic [1:0]  r_init_cnt;
    logic        r_pend;
    logic        r_ptr;          // 0: D0 preferred, 1: D1 preferred
    logic [1:0]  r_win;
    logic        w_any;
    logic [1:0]  w_pick;
    logic        w_sel_we;
    logic [23:0] w_sel_a;
    logic [7:0]  w_sel_wd;
    logic        w_enter_done;

    logic        r_rdcmd;
    logic        r_wrcmd;
    logic [23:0] r_a;
    logic [7:0]  r_wrd;
    logic [7:0]  r_cpurd;
    logic [7:0]  r_d0rd;
    logic [7:0]  r_d1rd;
    logic        r_cpudone;
    logic        r_d0done;
    logic        r_d1done;

    phi2_sync u_sync (
        .i_clk   (i_c8m),
        .i_reset (i_reset),
        .i_phi2  (i_phi2),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    // Winner selection: CPU absolute, then the preferred DMA port, then the other.
    always_comb begin
        w_any  = 1'b0;
        w_pick = PORT_CPU;
        if (r_init_cnt >= INIT_N) begin
            if (i_cpureq) begin
                w_any  = 1'b1;
                w_pick = PORT_CPU;
            end else if (i_d0req && (!r_ptr || !i_d1req)) begin
                w_any  = 1'b1;
                w_pick = PORT_D0;
            end else if (i_d1req) begin
                w_any  = 1'b1;
                w_pick = PORT_D1;
            end
        end
    end

    // Route the winner's access fields toward the command registers.
    always_comb begin
        w_sel_we = i_cpuwe;
        w_sel_a  = i_cpua;
        w_sel_wd = i_cpuwd;
        case (w_pick)
            PORT_D0: begin
                w_sel_we = i_d0we;
                w_sel_a  = i_d0a;
                w_sel_wd = i_d0wd;
            end
            PORT_D1: begin
                w_sel_we = i_d1we;
                w_sel_a  = i_d1a;
                w_sel_wd = i_d1wd;
            end
            default: ;
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_c8m) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    // FSM next state: one slot per PHI2 cycle, read latency counted from fall.
    always_comb begin
        w_next       = r_state;
        w_enter_done = 1'b0;
        case (r_state)
            ST_IDLE:  if (w_rise) w_next = ST_ARB;
            ST_ARB:   w_next = w_any ? ST_ARMED : ST_IDLE;
            ST_ARMED: if (w_fall) w_next = ST_WAIT;
            ST_WAIT: begin
                if (r_cnt == LAT_M1) begin
                    w_next       = ST_DONE;
                    w_enter_done = 1'b1;
                end
            end
            ST_DONE:  w_next = (r_pend || w_rise) ? ST_ARB : ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Latency counter, rise-pending latch and post-reset init slot counter.
    always_ff @(posedge i_c8m) begin
        if (i_reset) begin
            r_cnt      <= 4'd0;
            r_pend     <= 1'b0;
            r_init_cnt <= 2'd0;
        end else begin
            r_cnt <= (r_state == ST_WAIT) ? r_cnt + 4'd1 : 4'd0;
            if (w_next == ST_ARB)
                r_pend <= 1'b0;
            else if (w_rise && (r_state == ST_WAIT || r_state == ST_DONE))
                r_pend <= 1'b1;
            if (w_fall && r_init_cnt != 2'd3)
                r_init_cnt <= r_init_cnt + 2'd1;
        end
    end

    // Command/address registers, RR pointer, read capture and DONE pulses.
    always_ff @(posedge i_c8m) begin
        if (i_reset) begin
            r_rdcmd   <= 1'b0;
            r_wrcmd   <= 1'b0;
            r_a       <= 24'd0;
            r_wrd     <= 8'd0;
            r_ptr     <= 1'b0;
            r_win     <= PORT_CPU;
            r_cpurd   <= 8'd0;
            r_d0rd    <= 8'd0;
            r_d1rd    <= 8'd0;
            r_cpudone <= 1'b0;
            r_d0done  <= 1'b0;
            r_d1done  <= 1'b0;
        end else begin
            r_cpudone <= 1'b0;
            r_d0done  <= 1'b0;
            r_d1done  <= 1'b0;
            if (r_state == ST_ARB && w_any) begin
                r_win   <= w_pick;
                r_a     <= w_sel_a;
                r_wrd   <= w_sel_wd;
                r_rdcmd <= ~w_sel_we;
                r_wrcmd <= w_sel_we;
                if (w_pick != PORT_CPU)
                    r_ptr <= (w_pick == PORT_D0);
            end
            if (w_enter_done) begin
                case (r_win)
                    PORT_D0: begin
                        r_d0done <= 1'b1;
                        if (r_rdcmd) r_d0rd <= i_rdd;
                    end
                    PORT_D1: begin
                        r_d1done <= 1'b1;
                        if (r_rdcmd) r_d1rd <= i_rdd;
                    end
                    default: begin
                        r_cpudone <= 1'b1;
                        if (r_rdcmd) r_cpurd <= i_rdd;
                    end
                endcase
            end
            if (r_state == ST_DONE) begin
                r_rdcmd <= 1'b0;
                r_wrcmd <= 1'b0;
            end
        end
    end

    assign o_rdcmd   = r_rdcmd;
    assign o_wrcmd   = r_wrcmd;
    assign o_a       = r_a;
    assign o_wrd     = r_wrd;
    assign o_cpurd   = r_cpurd;
    assign o_d0rd    = r_d0rd;
    assign o_d1rd    = r_d1rd;
    assign o_cpudone = r_cpudone;
    assign o_d0done  = r_d0done;
    assign o_d1done  = r_d1done;

endmodule
